// File: rtl/deit_requant_drain.sv
`default_nettype none
// ============================================================================
// Module   : deit_requant_drain
// Brief    : Drains accumulator rows, requantizes each column to int8 and
//            streams the rows out over AXI-Stream through a 4-deep FIFO.
// Revision : 1.0
// ============================================================================
module deit_requant_drain #(
    parameter int ARRAY_COL  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    input  logic [ADDR_WIDTH:0]        cfg_rows,
    input  logic [15:0]                cfg_mult,
    input  logic [4:0]                 cfg_shift,
    input  logic [7:0]                 cfg_zero_point,
    output logic                       acc_rd_en,
    output logic [ADDR_WIDTH-1:0]      acc_rd_addr,
    input  logic [ARRAY_COL*ACC_W-1:0] acc_rd_data,
    output logic [ARRAY_COL*8-1:0]     m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    localparam int ROW_W = ARRAY_COL * 8;
    localparam int P_W   = ACC_W + 17;
    localparam int R_W   = P_W + 1;
    localparam logic [ADDR_WIDTH:0] C_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] rows_q, rows_d;
    logic [ADDR_WIDTH:0] rd_cnt_q, rd_cnt_d;
    logic [15:0]         mult_q, mult_d;
    logic [4:0]          shift_q, shift_d;
    logic [7:0]          zp_q, zp_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic [ROW_W-1:0]    fifo_data_q [4];
    logic [ROW_W-1:0]    fifo_data_d [4];
    logic [3:0]          fifo_last_q, fifo_last_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [2:0]          count_q, count_d;

    logic [ROW_W-1:0]    w_row;
    logic                w_credit_ok;
    logic                w_pop;
    logic [ADDR_WIDTH:0] w_rd_next;

    // Requantization of the row returning from the accumulator this cycle
    for (genvar c = 0; c < ARRAY_COL; c++) begin : g_col
        logic signed [P_W-1:0] w_acc_ext;
        logic signed [P_W-1:0] w_mult_ext;
        logic signed [P_W-1:0] w_prod;
        logic signed [R_W-1:0] w_rnd;
        logic signed [R_W-1:0] w_sum;
        logic signed [R_W-1:0] w_shifted;
        logic signed [R_W:0]   w_res;
        logic [7:0]            w_sat;

        localparam logic signed [R_W:0] C_MAX = (R_W+1)'(127);
        localparam logic signed [R_W:0] C_MIN = -(R_W+1)'(128);

        assign w_acc_ext  = P_W'($signed(acc_rd_data[c*ACC_W +: ACC_W]));
        assign w_mult_ext = $signed(P_W'(mult_q));
        assign w_prod     = w_acc_ext * w_mult_ext;
        assign w_rnd      = (shift_q == 5'd0) ? '0 : (R_W'(1) << (shift_q - 5'd1));
        assign w_sum      = R_W'(w_prod) + w_rnd;
        assign w_shifted  = w_sum >>> shift_q;
        assign w_res      = (R_W+1)'(w_shifted) + (R_W+1)'($signed(zp_q));

        always_comb begin
            w_sat = w_res[7:0];
            if (w_res > C_MAX) begin
                w_sat = 8'h7F;
            end else if (w_res < C_MIN) begin
                w_sat = 8'h80;
            end
        end

        assign w_row[c*8 +: 8] = w_sat;
    end

    assign ap_idle       = (state_q == S_IDLE);
    assign acc_rd_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
    assign m_axis_tvalid = (count_q != 3'd0);
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[rd_ptr_q];

    // Rows already buffered plus the one still returning must leave room
    assign w_credit_ok = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_rd_next   = rd_cnt_q + C_ONE;

    always_comb begin
        state_d         = state_q;
        rows_d          = rows_q;
        rd_cnt_d        = rd_cnt_q;
        mult_d          = mult_q;
        shift_d         = shift_q;
        zp_d            = zp_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        acc_rd_en       = 1'b0;
        ap_done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    rows_d   = cfg_rows;
                    mult_d   = cfg_mult;
                    shift_d  = cfg_shift;
                    zp_d     = cfg_zero_point;
                    rd_cnt_d = '0;
                    state_d  = (cfg_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_credit_ok) begin
                    acc_rd_en       = 1'b1;
                    rd_cnt_d        = w_rd_next;
                    inflight_d      = 1'b1;
                    inflight_last_d = (w_rd_next == rows_q);
                    if (w_rd_next == rows_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_pop && m_axis_tlast) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = w_row;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, inflight_q} - {2'b00, w_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rows_q          <= '0;
            rd_cnt_q        <= '0;
            mult_q          <= '0;
            shift_q         <= '0;
            zp_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q     <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            rows_q          <= rows_d;
            rd_cnt_q        <= rd_cnt_d;
            mult_q          <= mult_d;
            shift_q         <= shift_d;
            zp_q            <= zp_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
            end
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

endmodule
`default_nettype wire
